// File: rtl/mnist_pkg.sv
// Constants and state encoding shared by the MNIST inference controller and its
// output stage.
package mnist_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W_DEF = 24;
    localparam int IDX_W       = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESOLVE = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/argmax_tracker.sv
// Running max / runner-up / tie tracker over one inference's class scores.
// Also keeps the seen-mask that rejects duplicate and out-of-range indices.
module argmax_tracker #(
    parameter int SCORE_W     = mnist_pkg::SCORE_W_DEF,
    parameter int NUM_CLASSES = mnist_pkg::NUM_CLASSES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          in_en,
    input  logic [mnist_pkg::IDX_W-1:0]   idx,
    input  logic signed [SCORE_W-1:0]     data,
    output logic                          acc,
    output logic                          bad,
    output logic [mnist_pkg::IDX_W-1:0]   max_idx,
    output logic signed [SCORE_W-1:0]     max_val,
    output logic signed [SCORE_W-1:0]     run_val,
    output logic                          tie,
    output logic [mnist_pkg::IDX_W:0]     cnt
);
    import mnist_pkg::*;

    localparam logic signed [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]          IDX_LIM  = IDX_W'(NUM_CLASSES);

    logic [NUM_CLASSES-1:0] seen;
    logic                   oor;
    logic                   dup;

    assign oor = (idx >= IDX_LIM);
    assign dup = ~oor & seen[idx];
    assign acc = in_en & ~oor & ~dup;
    assign bad = in_en & (oor | dup);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen    <= '0;
            cnt     <= '0;
            max_idx <= '0;
            max_val <= '0;
            run_val <= '0;
            tie     <= 1'b0;
        end else if (clr) begin
            seen    <= '0;
            cnt     <= '0;
            max_idx <= '0;
            max_val <= '0;
            run_val <= '0;
            tie     <= 1'b0;
        end else if (acc) begin
            seen[idx] <= 1'b1;
            cnt       <= cnt + 1'b1;
            if (cnt == '0) begin
                max_idx <= idx;
                max_val <= data;
                run_val <= MOST_NEG;
                tie     <= 1'b0;
            end else if (data > max_val) begin
                run_val <= max_val;
                max_val <= data;
                max_idx <= idx;
                tie     <= 1'b0;
            end else if (data == max_val) begin
                // earlier arrival keeps the win; the equal score becomes runner-up
                tie     <= 1'b1;
                run_val <= data;
            end else if (data > run_val) begin
                run_val <= data;
            end
        end
    end

endmodule

// File: rtl/digit_argmax.sv
// Inference output stage: collects class scores, resolves the winning digit on a
// check_max rising edge and offers it to the sink over valid/ready.
module digit_argmax #(
    parameter int SCORE_W     = mnist_pkg::SCORE_W_DEF,
    parameter int NUM_CLASSES = mnist_pkg::NUM_CLASSES,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          score_valid,
    input  logic [mnist_pkg::IDX_W-1:0]   score_idx,
    input  logic signed [SCORE_W-1:0]     score_data,
    input  logic                          check_max,
    input  logic                          result_ready,
    output logic                          result_valid,
    output logic [mnist_pkg::IDX_W-1:0]   result_digit,
    output logic signed [SCORE_W-1:0]     result_score,
    output logic [SCORE_W-1:0]            result_margin,
    output logic                          result_tie,
    output logic                          result_err,
    output logic [CNT_W-1:0]              inference_count
);
    import mnist_pkg::*;

    localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(NUM_CLASSES);
    localparam logic [IDX_W:0] CNT_TWO  = (IDX_W+1)'(2);

    state_t                    state, state_nxt;
    logic                      chk_q;
    logic                      req_p0;
    logic                      err_q;
    logic                      collecting;
    logic                      in_en;
    logic                      clr;
    logic                      acc;
    logic                      bad;
    logic                      tie;
    logic [IDX_W-1:0]          max_idx;
    logic signed [SCORE_W-1:0] max_val;
    logic signed [SCORE_W-1:0] run_val;
    logic [IDX_W:0]            cnt;
    logic signed [SCORE_W:0]   diff_p0;
    logic [SCORE_W-1:0]        margin_p0;
    logic                      err_p0;

    function automatic logic [SCORE_W-1:0] sat_margin(input logic signed [SCORE_W:0] d);
        logic signed [SCORE_W:0] lim;
        lim = $signed({1'b0, {SCORE_W{1'b1}}});
        if (d[SCORE_W])
            return '0;
        else if (d > lim)
            return '1;
        else
            return d[SCORE_W-1:0];
    endfunction

    assign collecting = (state == IDLE) || (state == COLLECT);
    assign in_en      = score_valid & collecting;

    argmax_tracker #(
        .SCORE_W     (SCORE_W),
        .NUM_CLASSES (NUM_CLASSES)
    ) u_tracker (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .in_en   (in_en),
        .idx     (score_idx),
        .data    (score_data),
        .acc     (acc),
        .bad     (bad),
        .max_idx (max_idx),
        .max_val (max_val),
        .run_val (run_val),
        .tie     (tie),
        .cnt     (cnt)
    );

    // RESOLVE stage: margin and final error status from the frozen tracker
    assign diff_p0   = $signed({max_val[SCORE_W-1], max_val}) - $signed({run_val[SCORE_W-1], run_val});
    assign margin_p0 = (cnt < CNT_TWO) ? '0 : sat_margin(diff_p0);
    assign err_p0    = err_q | score_valid | (cnt != CNT_FULL);

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_p0)
                    state_nxt = RESOLVE;
                else if (acc)
                    state_nxt = COLLECT;
            end
            COLLECT: begin
                if (req_p0)
                    state_nxt = RESOLVE;
            end
            RESOLVE: state_nxt = HOLD;
            HOLD: begin
                if (result_ready) begin
                    state_nxt = IDLE;
                    clr       = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request is registered; rising edges while a result is pending are dropped here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            chk_q  <= 1'b0;
            req_p0 <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            chk_q  <= check_max;
            req_p0 <= check_max & ~chk_q & collecting;
            if (clr)
                err_q <= 1'b0;
            else if (bad)
                err_q <= 1'b1;
        end
    end

    // HOLD stage: result fields frozen until the sink accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid    <= 1'b0;
            result_digit    <= '0;
            result_score    <= '0;
            result_margin   <= '0;
            result_tie      <= 1'b0;
            result_err      <= 1'b0;
            inference_count <= '0;
        end else if (state == RESOLVE) begin
            result_valid  <= 1'b1;
            result_digit  <= max_idx;
            result_score  <= max_val;
            result_margin <= margin_p0;
            result_tie    <= tie;
            result_err    <= err_p0;
        end else if (clr) begin
            result_valid    <= 1'b0;
            inference_count <= inference_count + 1'b1;
        end
    end

endmodule
